// File: rtl/pwm_meter_if.sv
// pwm_meter_if: signal bundle between a PWM source/consumer and pwm_meter.
//
// Signals:
//   pwm_in      raw PWM waveform, asynchronous to the meter clock
//   enable      level enable; low holds the meter idle
//   high_cnt    high time of the last complete period (clk cycles)
//   period_cnt  length of the last complete period (clk cycles)
//   ovf         the published measurement saturated
//   meas_valid  one-cycle pulse when the result fields update
//   stuck       no edge seen for TIMEOUT cycles (timeout build only)
//   stuck_level level of pwm_in while stuck is high
//   state_dbg   current meter FSM state, for observation only
//
// Handshake: meas_valid is a valid-only strobe with no ready. The result
// fields change only in the cycle meas_valid is high and hold otherwise, so
// a consumer that misses a pulse simply reads the held values.
//
// Modports: master = the side driving pwm_in/enable and reading results,
//           slave  = the meter itself.

interface pwm_meter_if #(
  parameter int CNT_W = 32
);
  logic             pwm_in;
  logic             enable;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             ovf;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;
  logic [1:0]       state_dbg;

  modport master (
    output pwm_in, enable,
    input  high_cnt, period_cnt, ovf, meas_valid, stuck, stuck_level, state_dbg
  );

  modport slave (
    input  pwm_in, enable,
    output high_cnt, period_cnt, ovf, meas_valid, stuck, stuck_level, state_dbg
  );
endinterface

// File: rtl/pwm_meter.sv
// pwm_meter: measures high time and period of a PWM waveform in clk cycles
// and publishes one result per PWM period.
//
// Parameters:
//   CNT_W    width of the high/low counters and result fields
//   TIMEOUT  edge-free cycles before a stuck line is reported
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pwm_meter_if slave modport (pwm_in, enable in; results out)
//
// Optional feature: define PWM_METER_TIMEOUT_EN to build the stuck-line
// timeout. Without it stuck/stuck_level are tied low and a line with no
// edges just leaves the counters saturating.

module pwm_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  pwm_meter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Two-flop synchronizer (s1, s2) plus one delay flop (p) for edge detect.
  logic s1_q, s2_q, p_q;
  logic rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, l_q, l_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [CNT_W:0]   sum_w;
  logic             sum_sat;
  logic [CNT_W-1:0] sum_clamp;

  assign rise = s2_q & ~p_q;
  assign fall = ~s2_q & p_q;

  // Period length is formed one bit wider so an overflow is visible and
  // can be clamped instead of wrapping.
  assign sum_w     = {1'b0, h_q} + {1'b0, l_q};
  assign sum_sat   = sum_w[CNT_W];
  assign sum_clamp = sum_sat ? CNT_MAX : sum_w[CNT_W-1:0];

`ifdef PWM_METER_TIMEOUT_EN
  localparam int T_W = $clog2(TIMEOUT + 1);
  logic [T_W-1:0] t_q, t_d;
  logic           stuck_q, stuck_d, lvl_q, lvl_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    l_d      = l_q;
    sat_d    = sat_q;
    high_d   = high_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
`ifdef PWM_METER_TIMEOUT_EN
    t_d      = t_q;
    stuck_d  = stuck_q;
    lvl_d    = lvl_q;
`endif

    if (!bus.enable) begin
      // Disable wins over everything, including a coincident rise.
      state_d = ST_IDLE;
      h_d     = '0;
      l_d     = '0;
      sat_d   = 1'b0;
`ifdef PWM_METER_TIMEOUT_EN
      t_d     = '0;
      stuck_d = 1'b0;
      lvl_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
        end
        ST_ARM: begin
          // Whatever part-period is on the line now is discarded.
          if (rise) begin
            state_d = ST_HIGH;
            h_d     = CNT_ONE;
            l_d     = '0;
            sat_d   = 1'b0;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state_d = ST_LOW;
            l_d     = CNT_ONE;
          end else if (h_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            h_d = h_q + CNT_ONE;
          end
        end
        ST_LOW: begin
          if (rise) begin
            high_d   = h_q;
            period_d = sum_clamp;
            ovf_d    = sat_q | sum_sat;
            valid_d  = 1'b1;
            state_d  = ST_HIGH;
            h_d      = CNT_ONE;
            l_d      = '0;
            sat_d    = 1'b0;
          end else if (l_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            l_d = l_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

`ifdef PWM_METER_TIMEOUT_EN
      if (state_q == ST_IDLE) begin
        t_d     = '0;
        stuck_d = 1'b0;
        lvl_d   = 1'b0;
      end else if (rise || fall) begin
        t_d     = '0;
        stuck_d = 1'b0;
        lvl_d   = 1'b0;
      end else if (t_q == T_W'(TIMEOUT - 1)) begin
        // TIMEOUT edge-free cycles: report the stuck level as a synthetic
        // period and re-arm, so this repeats every TIMEOUT cycles.
        stuck_d  = 1'b1;
        lvl_d    = s2_q;
        high_d   = s2_q ? CNT_W'(TIMEOUT) : '0;
        period_d = CNT_W'(TIMEOUT);
        ovf_d    = 1'b0;
        valid_d  = 1'b1;
        state_d  = ST_ARM;
        h_d      = '0;
        l_d      = '0;
        sat_d    = 1'b0;
        t_d      = '0;
      end else begin
        t_d = t_q + T_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      p_q      <= 1'b0;
      state_q  <= ST_IDLE;
      h_q      <= '0;
      l_q      <= '0;
      sat_q    <= 1'b0;
      high_q   <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      s1_q     <= bus.pwm_in;
      s2_q     <= s1_q;
      p_q      <= s2_q;
      state_q  <= state_d;
      h_q      <= h_d;
      l_q      <= l_d;
      sat_q    <= sat_d;
      high_q   <= high_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

`ifdef PWM_METER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q     <= '0;
      stuck_q <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      t_q     <= t_d;
      stuck_q <= stuck_d;
      lvl_q   <= lvl_d;
    end
  end

  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = lvl_q;
`else
  assign bus.stuck       = 1'b0;
  assign bus.stuck_level = 1'b0;
`endif

  assign bus.high_cnt   = high_q;
  assign bus.period_cnt = period_q;
  assign bus.ovf        = ovf_q;
  assign bus.meas_valid = valid_q;
  assign bus.state_dbg  = state_q;

endmodule
